axi_early_wdata_sub: RTL and testbench

//  AXI5 write-channel subordinate front end for the early-write-data configuration.

---
 rtl/axi_early_wdata_sub.sv | 216 +++++++++++++++++++++
 tb/tb_axi_early_wdata_sub.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_early_wdata_sub.sv
// AXI5 write-channel subordinate front end with early write data.
// W beats are buffered independently of AW, then paired in order with queued
// AW bursts; each beat goes out on a simple memory write port with its computed
// address, and one B response is returned per burst.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   aw*  (awvalid/awready/awid/awaddr/awlen/awsize/awburst)  write address channel
//   w*   (wvalid/wready/wdata/wstrb/wlast)                  write data channel
//   b*   (bvalid/bready/bid/bresp)                          write response channel
//   wr_* (wr_valid/wr_ready/wr_addr/wr_data/wr_strb/wr_last) memory write port
module axi_early_wdata_sub #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 64,
   parameter int unsigned ID_W_WIDTH  = 3,
   parameter int unsigned BRESP_WIDTH = 2,
   parameter int unsigned WDATA_DEPTH = 16,
   parameter int unsigned AW_DEPTH    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ID_W_WIDTH-1:0]   awid,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [7:0]              awlen,
   input  logic [2:0]              awsize,
   input  logic [1:0]              awburst,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   output logic                    bvalid,
   input  logic                    bready,
   output logic [ID_W_WIDTH-1:0]   bid,
   output logic [BRESP_WIDTH-1:0]  bresp,
   output logic                    wr_valid,
   input  logic                    wr_ready,
   output logic [ADDR_WIDTH-1:0]   wr_addr,
   output logic [DATA_WIDTH-1:0]   wr_data,
   output logic [DATA_WIDTH/8-1:0] wr_strb,
   output logic                    wr_last
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned WPTR_W     = $clog2(WDATA_DEPTH);
   localparam int unsigned WCNT_W     = WPTR_W + 1;
   localparam int unsigned APTR_W     = $clog2(AW_DEPTH);
   localparam int unsigned ACNT_W     = APTR_W + 1;
   localparam int unsigned AWE_W      = ID_W_WIDTH + ADDR_WIDTH + 8 + 3 + 2;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   typedef enum logic [1:0] {IDLE, BURST, RESP} state_t;

   state_t state, state_nxt;

   // W beat FIFO
   logic [DATA_WIDTH-1:0] wf_data [WDATA_DEPTH];
   logic [STRB_WIDTH-1:0] wf_strb [WDATA_DEPTH];
   logic                  wf_last [WDATA_DEPTH];
   logic [WPTR_W-1:0]     wf_wp, wf_rp;
   logic [WCNT_W-1:0]     wf_cnt, wf_cnt_nxt;
   logic                  w_push, w_pop;

   // AW request FIFO
   logic [AWE_W-1:0]      aw_mem [AW_DEPTH];
   logic [APTR_W-1:0]     aw_wp, aw_rp;
   logic [ACNT_W-1:0]     aw_cnt, aw_cnt_nxt;
   logic                  aw_push, aw_pop;

   logic [ID_W_WIDTH-1:0] h_id;
   logic [ADDR_WIDTH-1:0] h_addr;
   logic [7:0]            h_len;
   logic [2:0]            h_size;
   logic [1:0]            h_burst;

   // Current burst context
   logic [ID_W_WIDTH-1:0] cur_id;
   logic [ADDR_WIDTH-1:0] cur_addr, addr_nxt;
   logic [7:0]            cur_len, beat;
   logic [2:0]            cur_size;
   logic [1:0]            mode, ld_mode;
   logic                  err, ld_err;

   assign w_push     = wvalid && wready;
   assign aw_push    = awvalid && awready;
   assign w_pop      = wr_valid && wr_ready;
   assign wf_cnt_nxt = wf_cnt + WCNT_W'(w_push) - WCNT_W'(w_pop);
   assign aw_cnt_nxt = aw_cnt + ACNT_W'(aw_push) - ACNT_W'(aw_pop);

   assign {h_id, h_addr, h_len, h_size, h_burst} = aw_mem[aw_rp];

   // FIFO storage; contents need no reset, only the pointers do
   always_ff @(posedge clk) begin
      if (w_push) begin
         wf_data[wf_wp] <= wdata;
         wf_strb[wf_wp] <= wstrb;
         wf_last[wf_wp] <= wlast;
      end
      if (aw_push) aw_mem[aw_wp] <= {awid, awaddr, awlen, awsize, awburst};
   end

   // FIFO control; ready reflects the post-update occupancy so a full FIFO never
   // accepts a push even when it pops in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         wf_wp   <= '0;
         wf_rp   <= '0;
         wf_cnt  <= '0;
         wready  <= 1'b0;
         aw_wp   <= '0;
         aw_rp   <= '0;
         aw_cnt  <= '0;
         awready <= 1'b0;
      end else begin
         if (w_push)  wf_wp <= wf_wp + WPTR_W'(1);
         if (w_pop)   wf_rp <= wf_rp + WPTR_W'(1);
         if (aw_push) aw_wp <= aw_wp + APTR_W'(1);
         if (aw_pop)  aw_rp <= aw_rp + APTR_W'(1);
         wf_cnt  <= wf_cnt_nxt;
         aw_cnt  <= aw_cnt_nxt;
         wready  <= (wf_cnt_nxt != WCNT_W'(WDATA_DEPTH));
         awready <= (aw_cnt_nxt != ACNT_W'(AW_DEPTH));
      end
   end

   // Decode of the AW head: invalid WRAP and reserved bursts fall back to INCR
   always_comb begin
      logic [ADDR_WIDTH-1:0] h_mask;
      logic                  wrap_ok;
      h_mask  = (ADDR_WIDTH'(1) << h_size) - ADDR_WIDTH'(1);
      wrap_ok = ((h_len == 8'd1) || (h_len == 8'd3) || (h_len == 8'd7) || (h_len == 8'd15))
                && ((h_addr & h_mask) == '0);
      ld_mode = BURST_INCR;
      ld_err  = 1'b0;
      case (h_burst)
         BURST_FIXED: ld_mode = BURST_FIXED;
         BURST_WRAP: begin
            ld_mode = wrap_ok ? BURST_WRAP : BURST_INCR;
            ld_err  = !wrap_ok;
         end
         BURST_RSVD: ld_err = 1'b1;
         default:    ld_mode = BURST_INCR;
      endcase
   end

   // Next beat address; the wrap region is a power of two so mod is a mask
   always_comb begin
      logic [ADDR_WIDTH-1:0] nbytes, rmask;
      nbytes   = ADDR_WIDTH'(1) << cur_size;
      rmask    = ((ADDR_WIDTH'(cur_len) + ADDR_WIDTH'(1)) << cur_size) - ADDR_WIDTH'(1);
      addr_nxt = (cur_addr & ~(nbytes - ADDR_WIDTH'(1))) + nbytes;
      if (mode == BURST_FIXED)     addr_nxt = cur_addr;
      else if (mode == BURST_WRAP) addr_nxt = (cur_addr & ~rmask) | ((cur_addr + nbytes) & rmask);
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      aw_pop    = 1'b0;
      case (state)
         IDLE: begin
            if (aw_cnt != '0) begin
               aw_pop    = 1'b1;
               state_nxt = BURST;
            end
         end
         BURST:   if (w_pop && (beat == cur_len)) state_nxt = RESP;
         RESP:    if (bready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and burst context
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cur_id   <= '0;
         cur_addr <= '0;
         cur_len  <= '0;
         cur_size <= '0;
         mode     <= BURST_INCR;
         beat     <= '0;
         err      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (aw_pop) begin
            cur_id   <= h_id;
            cur_addr <= h_addr;
            cur_len  <= h_len;
            cur_size <= h_size;
            mode     <= ld_mode;
            beat     <= '0;
            err      <= ld_err;
         end else if (w_pop) begin
            cur_addr <= addr_nxt;
            beat     <= beat + 8'd1;
            if (wf_last[wf_rp] != (beat == cur_len)) err <= 1'b1;
         end
      end
   end

   assign wr_valid = (state == BURST) && (wf_cnt != '0);
   assign wr_addr  = cur_addr;
   assign wr_data  = wf_data[wf_rp];
   assign wr_strb  = wf_strb[wf_rp];
   assign wr_last  = (beat == cur_len);
   assign bvalid   = (state == RESP);
   assign bid      = cur_id;
   assign bresp    = (bvalid && err) ? BRESP_WIDTH'(2) : '0;

endmodule

// File: tb/tb_axi_early_wdata_sub.sv
// Self-checking bench for axi_early_wdata_sub: directed scenarios plus a
// randomized phase, checked against a burst-level reference model.
module tb_axi_early_wdata_sub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        awvalid = 1'b0, awready;
   logic [2:0]  awid = '0;
   logic [31:0] awaddr = '0;
   logic [7:0]  awlen = '0;
   logic [2:0]  awsize = '0;
   logic [1:0]  awburst = '0;
   logic        wvalid = 1'b0, wready;
   logic [63:0] wdata = '0;
   logic [7:0]  wstrb = '0;
   logic        wlast = 1'b0;
   logic        bvalid, bready = 1'b1;
   logic [2:0]  bid;
   logic [1:0]  bresp;
   logic        wr_valid, wr_ready = 1'b1;
   logic [31:0] wr_addr;
   logic [63:0] wr_data;
   logic [7:0]  wr_strb;
   logic        wr_last;

   always #5 clk = ~clk;

   axi_early_wdata_sub dut (
      .clk(clk), .rst(rst),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
      .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_last(wr_last)
   );

   typedef struct {int id; longint unsigned addr; int len; int size; int burst;} awreq_t;
   typedef struct {logic [63:0] data; logic [7:0] strb; logic last;} wbeat_t;
   typedef struct {logic [63:0] addr; logic [63:0] data; logic [7:0] strb; logic last;} beat_t;
   typedef struct {logic [63:0] id; logic [63:0] resp;} b_t;

   awreq_t m_aw[$];
   wbeat_t m_w[$];
   beat_t  exp_wr[$], obs_wr[$];
   b_t     exp_b[$], obs_b[$];
   int     obs_wr_cyc[$], obs_b_cyc[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int aw_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Record handshakes mid-cycle, where all signals are settled
   always @(negedge clk) begin
      if (!rst && wr_valid && wr_ready) begin
         obs_wr.push_back('{addr: 64'(wr_addr), data: wr_data, strb: wr_strb, last: wr_last});
         obs_wr_cyc.push_back(cyc);
      end
      if (!rst && bvalid && bready) begin
         obs_b.push_back('{id: 64'(bid), resp: 64'(bresp)});
         obs_b_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic stop_now(input string why);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "stopping: %s", why);
   endtask

   task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic l);
      int t = 0;
      wvalid = 1'b1; wdata = d; wstrb = s; wlast = l;
      m_w.push_back('{data: d, strb: s, last: l});
      @(negedge clk);
      while (!wready && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) begin chk("w_accept_timeout", 64'(wready), 64'd1); stop_now("W stalled"); end
      @(posedge clk); #1;
      wvalid = 1'b0;
   endtask

   task automatic send_aw(input int id, input logic [31:0] a, input int len, input int sz, input int bu);
      int t = 0;
      awvalid = 1'b1; awid = 3'(id); awaddr = a; awlen = 8'(len); awsize = 3'(sz); awburst = 2'(bu);
      m_aw.push_back('{id: id, addr: 64'(a), len: len, size: sz, burst: bu});
      @(negedge clk);
      while (!awready && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) begin chk("aw_accept_timeout", 64'(awready), 64'd1); stop_now("AW stalled"); end
      aw_cyc = cyc;
      @(posedge clk); #1;
      awvalid = 1'b0;
   endtask

   // n random beats, wlast asserted only on index last_at
   task automatic send_beats(input int n, input int last_at);
      for (int i = 0; i < n; i++)
         send_w({$urandom, $urandom}, 8'($urandom), i == last_at);
   endtask

   // Reference: pair queued AW bursts with W beats in order and derive addresses/responses
   task automatic model_run();
      awreq_t a;
      wbeat_t w;
      longint unsigned nb, region, base, cur;
      bit err, wrap_ok;
      while (m_aw.size() > 0 && m_w.size() > m_aw[0].len) begin
         a       = m_aw.pop_front();
         nb      = 64'd1 << a.size;
         region  = 64'(a.len + 1) * nb;
         base    = (a.addr / region) * region;
         wrap_ok = (a.burst == 2) && (a.len == 1 || a.len == 3 || a.len == 7 || a.len == 15)
                   && (a.addr % nb == 0);
         err     = (a.burst == 3) || (a.burst == 2 && !wrap_ok);
         cur     = a.addr;
         for (int i = 0; i <= a.len; i++) begin
            w = m_w.pop_front();
            if (w.last != (i == a.len)) err = 1'b1;
            exp_wr.push_back('{addr: cur, data: w.data, strb: w.strb, last: (i == a.len)});
            if (a.burst == 0)  cur = a.addr;
            else if (wrap_ok)  cur = base + ((cur + nb - base) % region);
            else               cur = ((cur / nb) * nb + nb) % 64'h1_0000_0000;
         end
         exp_b.push_back('{id: 64'(a.id), resp: err ? 64'd2 : 64'd0});
      end
   endtask

   task automatic drain();
      int t = 0;
      model_run();
      while ((obs_wr.size() < exp_wr.size() || obs_b.size() < exp_b.size()) && t < 3000) begin
         @(negedge clk); t++;
      end
      repeat (4) @(negedge clk);
      chk("wr_beat_count", 64'(obs_wr.size()), 64'(exp_wr.size()));
      chk("b_count", 64'(obs_b.size()), 64'(exp_b.size()));
      for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
         chk($sformatf("wr_addr[%0d]", i), obs_wr[i].addr, exp_wr[i].addr);
         chk($sformatf("wr_data[%0d]", i), obs_wr[i].data, exp_wr[i].data);
         chk($sformatf("wr_strb[%0d]", i), 64'(obs_wr[i].strb), 64'(exp_wr[i].strb));
         chk($sformatf("wr_last[%0d]", i), 64'(obs_wr[i].last), 64'(exp_wr[i].last));
      end
      for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
         chk($sformatf("bid[%0d]", i), obs_b[i].id, exp_b[i].id);
         chk($sformatf("bresp[%0d]", i), obs_b[i].resp, exp_b[i].resp);
      end
      @(posedge clk); #1;
   endtask

   task automatic clear_all();
      obs_wr.delete(); obs_b.delete(); obs_wr_cyc.delete(); obs_b_cyc.delete();
      exp_wr.delete(); exp_b.delete(); m_aw.delete(); m_w.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      stop_now("watchdog");
   end

   initial begin
      bit done;
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", 64'(awready), 64'd0);
      chk("rst_wready", 64'(wready), 64'd0);
      chk("rst_bvalid", 64'(bvalid), 64'd0);
      chk("rst_wr_valid", 64'(wr_valid), 64'd0);
      chk("rst_bresp", 64'(bresp), 64'd0);
      chk("rst_bid", 64'(bid), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rel_awready", 64'(awready), 64'd1);
      chk("rel_wready", 64'(wready), 64'd1);
      @(posedge clk); #1;

      // W before AW, INCR, plus issue and response latency
      send_beats(4, 3);
      repeat (10) @(posedge clk); #1;
      send_aw(5, 32'h100, 3, 3, 1);
      drain();
      chk("t1_first_addr", obs_wr.size() > 0 ? obs_wr[0].addr : 64'hx, 64'h100);
      chk("t1_last_addr", obs_wr.size() > 3 ? obs_wr[3].addr : 64'hx, 64'h118);
      chk("t1_aw_to_wr", obs_wr_cyc.size() > 0 ? 64'(obs_wr_cyc[0] - aw_cyc) : 64'hx, 64'd2);
      chk("t1_wr_to_b", (obs_b_cyc.size() > 0 && obs_wr_cyc.size() > 3) ?
          64'(obs_b_cyc[0] - obs_wr_cyc[3]) : 64'hx, 64'd1);
      clear_all();

      // WRAP
      send_beats(4, 3);
      send_aw(2, 32'h38, 3, 3, 2);
      drain();
      chk("t2_wrap_addr1", obs_wr.size() > 1 ? obs_wr[1].addr : 64'hx, 64'h20);
      clear_all();

      // Backpressure: fill the W FIFO with the memory port stalled
      wr_ready = 1'b0;
      send_aw(3, 32'h1000, 15, 3, 1);
      send_beats(16, 15);
      repeat (2) @(negedge clk);
      chk("t3_wready_full", 64'(wready), 64'd0);
      chk("t3_wr_valid_held", 64'(wr_valid), 64'd1);
      @(posedge clk); #1 wr_ready = 1'b1;
      @(negedge clk);
      chk("t3_wready_before_pop", 64'(wready), 64'd0);
      @(negedge clk);
      chk("t3_wready_after_pop", 64'(wready), 64'd1);
      @(posedge clk); #1;
      drain();
      clear_all();

      // wlast mismatch, then a clean burst
      send_aw(6, 32'h200, 1, 3, 1);
      send_beats(2, 0);
      send_aw(7, 32'h300, 1, 3, 1);
      send_beats(2, 1);
      drain();
      clear_all();

      // Reserved burst type
      send_aw(4, 32'h333, 0, 2, 3);
      send_beats(1, 0);
      drain();
      clear_all();

      // Back-to-back AWs with data already buffered
      send_beats(2, 1);
      send_beats(2, 1);
      send_aw(1, 32'h500, 1, 2, 1);
      send_aw(2, 32'h600, 1, 2, 0);
      drain();
      chk("t5_b_to_next_burst", (obs_wr_cyc.size() > 2 && obs_b_cyc.size() > 0) ?
          64'(obs_wr_cyc[2] - obs_b_cyc[0]) : 64'hx, 64'd2);
      clear_all();

      // Reset in the middle of a burst
      wr_ready = 1'b0;
      send_aw(0, 32'h400, 3, 3, 1);
      send_beats(4, 3);
      repeat (3) @(posedge clk); #1 wr_ready = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      wr_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t6_beats_before_rst", 64'(obs_wr.size()), 64'd2);
      chk("t6_wr_valid", 64'(wr_valid), 64'd0);
      chk("t6_bvalid", 64'(bvalid), 64'd0);
      chk("t6_awready_in_rst", 64'(awready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      wr_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t6_awready_rel", 64'(awready), 64'd1);
      chk("t6_wready_rel", 64'(wready), 64'd1);
      repeat (6) @(negedge clk);
      chk("t6_no_stale_beats", 64'(obs_wr.size()), 64'd2);
      chk("t6_no_b", 64'(obs_b.size()), 64'd0);
      @(posedge clk); #1;
      clear_all();
      send_beats(2, 1);
      send_aw(3, 32'h800, 1, 3, 1);
      drain();
      clear_all();

      // Randomized bursts with random memory and B backpressure
      done = 1'b0;
      fork
         begin
            for (int n = 0; n < 25; n++) begin
               int len, sz, bu, lat;
               logic [31:0] a;
               len = $urandom_range(0, 15);
               sz  = $urandom_range(0, 3);
               bu  = $urandom_range(0, 3);
               a   = $urandom;
               if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
               lat = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len) : len;
               if ($urandom_range(0, 1) == 1) begin
                  send_aw($urandom_range(0, 7), a, len, sz, bu);
                  send_beats(len + 1, lat);
               end else begin
                  send_beats(len + 1, lat);
                  send_aw($urandom_range(0, 7), a, len, sz, bu);
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               wr_ready = ($urandom_range(0, 3) != 0);
               bready   = ($urandom_range(0, 1) == 1);
            end
            wr_ready = 1'b1;
            bready   = 1'b1;
         end
      join
      drain();
      clear_all();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
